div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_pkg.sv | 17 +
 rtl/div_negate.sv | 18 +
 rtl/div_iter.sv | 152 +++++++++++++++
 tb/tb_div_iter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg : shared types and constants for the iterative divider       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_pkg;

   localparam int DIV_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_negate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_negate : conditional two's-complement negation                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_negate #(
   parameter int WIDTH = 32
)(
   input  logic             en,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);

   // Negating the most-negative value wraps to itself, which reads as 2^(WIDTH-1) unsigned.
   assign y = en ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_iter : radix-2 restoring divider, signed/unsigned, fixed latency |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
)(
   input  logic             clk,
   input  logic             divrst,
   input  logic             start,
   input  logic             signdiv,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             dbz
);

   localparam int               C_CNT_W   = $clog2(WIDTH) + 1;
   localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
   localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

   div_state_t         r_state;
   div_state_t         w_state_nxt;
   logic [C_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic               r_qsign;
   logic               r_rsign;
   logic               r_zero;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_r;
   logic               r_dbz;

   logic [WIDTH-1:0]   w_amag;
   logic [WIDTH-1:0]   w_bmag;
   logic [WIDTH-1:0]   w_qfix;
   logic [WIDTH-1:0]   w_rfix;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;

   div_negate #(.WIDTH(WIDTH)) u_neg_a (
      .en (signdiv & a[WIDTH-1]),
      .x  (a),
      .y  (w_amag)
   );

   div_negate #(.WIDTH(WIDTH)) u_neg_b (
      .en (signdiv & b[WIDTH-1]),
      .x  (b),
      .y  (w_bmag)
   );

   div_negate #(.WIDTH(WIDTH)) u_fix_q (
      .en (r_qsign),
      .x  (r_quo),
      .y  (w_qfix)
   );

   div_negate #(.WIDTH(WIDTH)) u_fix_r (
      .en (r_rsign),
      .x  (r_rem),
      .y  (w_rfix)
   );

   // The remainder stays below the divisor, so WIDTH bits hold it between steps.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_div};

   always_ff @(posedge clk or posedge divrst) begin
      if (divrst) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = CALC;
         CALC:    if (r_cnt == C_LAST) w_state_nxt = FIX;
         FIX:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge divrst) begin
      if (divrst) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_div   <= '0;
         r_qsign <= 1'b0;
         r_rsign <= 1'b0;
         r_zero  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
         r_dbz   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_quo   <= w_amag;
                  r_div   <= w_bmag;
                  r_rem   <= '0;
                  r_qsign <= signdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_rsign <= signdiv & a[WIDTH-1];
                  r_zero  <= (b == '0);
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            CALC: begin
               r_cnt <= r_cnt + C_ONE;
               if (!w_diff[WIDTH]) begin
                  r_rem <= w_diff[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               // Divide-by-zero leaves the dividend magnitude as remainder; sign fix restores a.
               r_q    <= r_zero ? '1 : w_qfix;
               r_r    <= w_rfix;
               r_dbz  <= r_zero;
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign q    = r_q;
   assign r    = r_r;
   assign dbz  = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_iter : directed self-checking bench for div_iter (WIDTH=32)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_div_iter;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         divrst;
   logic         start;
   logic         signdiv;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         dbz;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   div_iter #(.WIDTH(W)) dut (
      .clk     (clk),
      .divrst  (divrst),
      .start   (start),
      .signdiv (signdiv),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .q       (q),
      .r       (r),
      .dbz     (dbz)
   );

   typedef struct {
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input logic sgn, input logic [W-1:0] av, input logic [W-1:0] bv);
      start   = 1'b1;
      signdiv = sgn;
      a       = av;
      b       = bv;
      @(posedge clk); #1;
      start   = 1'b0;
      a       = $urandom;
      b       = $urandom;
      signdiv = ~sgn;
   endtask

   // Returns edges from accept until done is seen (-1 on timeout), plus busy-shape errors.
   task automatic wait_done(output int n, output int busy_bad);
      n        = -1;
      busy_bad = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin
            n = i;
            if (busy) busy_bad++;
            break;
         end
         if (!busy) busy_bad++;
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int n;
      int bb;
      issue(v.sgn, v.a, v.b);
      chk({tag, " busy@accept"}, 64'(busy), 64'd1);
      wait_done(n, bb);
      chk({tag, " latency"}, 64'(n), 64'(LAT));
      chk({tag, " busy shape"}, 64'(bb), 64'd0);
      chk({tag, " q"}, 64'(q), 64'(v.q));
      chk({tag, " r"}, 64'(r), 64'(v.r));
      chk({tag, " dbz"}, 64'(dbz), 64'(v.dbz));
      @(posedge clk); #1;
      chk({tag, " done pulse width"}, 64'(done), 64'd0);
      chk({tag, " q hold"}, 64'(q), 64'(v.q));
   endtask

   initial begin
      int   n;
      int   bb;
      int   dones;
      vec_t v;

      divrst  = 1'b1;
      start   = 1'b0;
      signdiv = 1'b0;
      a       = '0;
      b       = '0;

      vecs[0]  = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
      vecs[2]  = '{1'b0, 32'hFFFFFFF9,  32'd2,        32'h7FFFFFFC, 32'd1,        1'b0};
      vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
      vecs[4]  = '{1'b0, 32'h12345678,  32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
      vecs[5]  = '{1'b1, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};
      vecs[6]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
      vecs[7]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
      vecs[8]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
      vecs[9]  = '{1'b0, 32'd5,         32'd9,        32'd0,        32'd5,        1'b0};
      vecs[10] = '{1'b1, 32'h80000000,  32'd1,        32'h80000000, 32'd0,        1'b0};
      vecs[11] = '{1'b0, 32'h80000000,  32'd1,        32'h80000000, 32'd0,        1'b0};
      vecs[12] = '{1'b1, 32'h80000000,  32'd2,        32'hC0000000, 32'd0,        1'b0};
      vecs[13] = '{1'b0, 32'd0,         32'd3,        32'd0,        32'd0,        1'b0};

      #12;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset q",    64'(q),    64'd0);
      chk("reset r",    64'(r),    64'd0);
      chk("reset dbz",  64'(dbz),  64'd0);
      @(posedge clk); #1;
      divrst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // Start while busy must be ignored.
      issue(1'b0, 32'd50, 32'd5);
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1; signdiv = 1'b1; a = 32'd9; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n, bb);
      chk("busy-start latency", 64'(n), 64'(LAT - 10));
      chk("busy-start q", 64'(q), 64'd10);
      chk("busy-start r", 64'(r), 64'd0);

      // Back-to-back: new request in the done cycle.
      issue(1'b0, 32'd33, 32'd4);
      chk("b2b busy", 64'(busy), 64'd1);
      chk("b2b done low", 64'(done), 64'd0);
      wait_done(n, bb);
      chk("b2b latency", 64'(n), 64'(LAT));
      chk("b2b busy shape", 64'(bb), 64'd0);
      chk("b2b q", 64'(q), 64'd8);
      chk("b2b r", 64'(r), 64'd1);

      // Asynchronous abort in the middle of CALC.
      issue(1'b0, 32'd1000, 32'd3);
      repeat (15) @(posedge clk);
      #3;
      divrst = 1'b1;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort q",    64'(q),    64'd0);
      chk("abort r",    64'(r),    64'd0);
      chk("abort dbz",  64'(dbz),  64'd0);
      @(posedge clk); #1;
      divrst = 1'b0;
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("abort no done", 64'(dones), 64'd0);
      v = '{1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0};
      run_vec("after abort", v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
